// File: rtl/brent_kung_adder_pipe.sv
// ============================================================================
// Module   : brent_kung_adder_pipe
// Purpose  : 3-stage pipelined Brent-Kung prefix adder/subtractor with
//            valid/ready handshake and signed-overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module brent_kung_adder_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf
);

  localparam int c_LVL = $clog2(WIDTH);

  // Node i is combined at up-sweep span s when it closes a block of 2*s bits.
  function automatic logic [2*WIDTH-1:0] bk_up(input int s,
                                               input logic [WIDTH-1:0] g,
                                               input logic [WIDTH-1:0] p);
    logic [WIDTH-1:0] m;
    m = '0;
    for (int i = WIDTH - 1; i >= 0; i--)
      m = (m << 1) | WIDTH'(((i + 1) % (2 * s)) == 0);
    return {g | (p & (g << s) & m), p & ((p << s) | ~m)};
  endfunction

  function automatic logic [WIDTH-1:0] bk_dn(input int s,
                                             input logic [WIDTH-1:0] g,
                                             input logic [WIDTH-1:0] p);
    logic [WIDTH-1:0] m;
    m = '0;
    for (int i = WIDTH - 1; i >= 0; i--)
      m = (m << 1) | WIDTH'((((i + 1) % (2 * s)) == s) && ((i + 1) > 2 * s));
    return g | (p & (g << s) & m);
  endfunction

  logic             w_adv;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_g0;
  logic [WIDTH:0]   w_cy;

  logic             r_v1, r_v2, r_v3;
  logic [WIDTH-1:0] r_g1, r_p1, r_p2;
  logic             r_ci1;
  logic [WIDTH:0]   r_c2;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry, r_ovf;

  assign w_adv    = out_ready | ~r_v3;
  assign in_ready = w_adv;
  assign w_b      = sub ? ~b : b;

  // Carry-in folded into bit 0 as a generate from position -1.
  assign w_g0 = r_g1 | {{(WIDTH-1){1'b0}}, r_p1[0] & r_ci1};

  for (genvar lv = 1; lv <= c_LVL; lv++) begin : g_up
    logic [WIDTH-1:0] w_g, w_p;
    if (lv == 1) begin : g_first
      assign {w_g, w_p} = bk_up(1, w_g0, r_p1);
    end else begin : g_next
      assign {w_g, w_p} = bk_up(1 << (lv - 1), g_up[lv-1].w_g, g_up[lv-1].w_p);
    end
  end

  for (genvar lv = c_LVL - 1; lv >= 1; lv--) begin : g_dn
    logic [WIDTH-1:0] w_g;
    if (lv == c_LVL - 1) begin : g_first
      assign w_g = bk_dn(1 << (lv - 1), g_up[c_LVL].w_g, g_up[c_LVL].w_p);
    end else begin : g_next
      assign w_g = bk_dn(1 << (lv - 1), g_dn[lv+1].w_g, g_up[c_LVL].w_p);
    end
  end

  assign w_cy = {g_dn[1].w_g, r_ci1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_v3    <= 1'b0;
      r_g1    <= '0;
      r_p1    <= '0;
      r_ci1   <= 1'b0;
      r_c2    <= '0;
      r_p2    <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_adv) begin
      r_v1 <= in_valid;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
      if (in_valid) begin
        r_g1  <= a & w_b;
        r_p1  <= a ^ w_b;
        r_ci1 <= sub | cin;
      end
      if (r_v1) begin
        r_c2 <= w_cy;
        r_p2 <= r_p1;
      end
      if (r_v2) begin
        r_sum   <= r_p2 ^ r_c2[WIDTH-1:0];
        r_carry <= r_c2[WIDTH];
        r_ovf   <= r_c2[WIDTH-1] ^ r_c2[WIDTH];
      end
    end
  end

  assign out_valid = r_v3;
  assign sum       = r_sum;
  assign carry     = r_carry;
  assign ovf       = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_brent_kung_adder_pipe.sv
// Bench for brent_kung_adder_pipe: directed 16-bit vectors, backpressure and
// reset corner cases, then random 32/64-bit traffic against an arithmetic model.
`default_nettype none

module tb_brent_kung_adder_pipe;

  localparam int NR  = 10000;
  localparam int LIM = 60000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        iv16, ir16, cin16, sub16, ov16, or16, cy16, ovf16;
  logic [15:0] a16, b16, sum16;
  logic        iv32, ir32, cin32, sub32, ov32, or32, cy32, ovf32;
  logic [31:0] a32, b32, sum32;
  logic        iv64, ir64, cin64, sub64, ov64, or64, cy64, ovf64;
  logic [63:0] a64, b64, sum64;

  brent_kung_adder_pipe #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .cin(cin16), .sub(sub16), .out_valid(ov16), .out_ready(or16),
    .sum(sum16), .carry(cy16), .ovf(ovf16));
  brent_kung_adder_pipe #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .cin(cin32), .sub(sub32), .out_valid(ov32), .out_ready(or32),
    .sum(sum32), .carry(cy32), .ovf(ovf32));
  brent_kung_adder_pipe #(.WIDTH(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64), .a(a64), .b(b64),
    .cin(cin64), .sub(sub64), .out_valid(ov64), .out_ready(or64),
    .sum(sum64), .carry(cy64), .ovf(ovf64));

  typedef struct {
    logic [15:0] a, b;
    logic        cin, sub;
    logic [15:0] s;
    logic        cy, ov;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [65:0] act, input logic [65:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Returns {ovf, carry, sum} from plain wide arithmetic on a w-bit datapath.
  function automatic logic [65:0] model(input int w, input logic [63:0] a,
                                        input logic [63:0] b, input logic cin,
                                        input logic sub);
    logic [64:0] mask, full;
    logic [63:0] aa, bb, s;
    logic        ci, cy, ov;
    mask = (65'd1 << w) - 65'd1;
    aa   = a & mask[63:0];
    bb   = (sub ? ~b : b) & mask[63:0];
    ci   = sub ? 1'b1 : cin;
    full = {1'b0, aa} + {1'b0, bb} + 65'(ci);
    s    = full[63:0] & mask[63:0];
    cy   = full[w];
    ov   = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
    return {ov, cy, s};
  endfunction

  task automatic run_vec(input vec_t v, input string nm);
    int lat;
    @(negedge clk);
    iv16 = 1'b1; a16 = v.a; b16 = v.b; cin16 = v.cin; sub16 = v.sub; or16 = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      iv16 = 1'b0;
      lat++;
    end while (!ov16 && lat < 8);
    check({nm, "_latency"}, 66'(lat), 66'd3);
    check({nm, "_result"}, {ovf16, cy16, 48'b0, sum16}, {v.ov, v.cy, 48'b0, v.s});
    @(negedge clk);
    check({nm, "_hold"}, 66'({ov16, ovf16, cy16, sum16}), 66'({1'b0, v.ov, v.cy, v.s}));
  endtask

  vec_t tbl[9];
  logic [15:0] bp_a[6], bp_b[6];
  logic [65:0] bp_q[$];
  logic [65:0] frozen;

  initial begin
    iv16 = 0; a16 = 0; b16 = 0; cin16 = 0; sub16 = 0; or16 = 0;
    iv32 = 0; a32 = 0; b32 = 0; cin32 = 0; sub32 = 0; or32 = 0;
    iv64 = 0; a64 = 0; b64 = 0; cin64 = 0; sub64 = 0; or64 = 0;

    tbl[0] = '{16'hCC2A, 16'hAA55, 1'b0, 1'b0, 16'h767F, 1'b1, 1'b1};
    tbl[1] = '{16'h7FFF, 16'h05DF, 1'b0, 1'b0, 16'h85DE, 1'b0, 1'b1};
    tbl[2] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[3] = '{16'h0F6A, 16'h005F, 1'b1, 1'b1, 16'h0F0B, 1'b1, 1'b0};
    tbl[4] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    tbl[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[6] = '{16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0};
    tbl[7] = '{16'h0005, 16'h0005, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[8] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("reset_state", 66'({ov16, ir16, ovf16, cy16, sum16}), 66'({1'b0, 1'b1, 18'b0}));
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Backpressure: out_ready low on cycles 4..6 of a 6-beat stream
    for (int i = 0; i < 6; i++) begin
      bp_a[i] = 16'($urandom);
      bp_b[i] = 16'($urandom);
    end
    begin
      int sent, got, cyc;
      logic [65:0] e;
      sent = 0; got = 0; cyc = 0;
      while (got < 6 && cyc < 30) begin
        @(negedge clk);
        cyc++;
        iv16 = (sent < 6);
        if (sent < 6) begin
          a16 = bp_a[sent]; b16 = bp_b[sent]; cin16 = sent[0]; sub16 = sent[1];
        end
        or16 = !(cyc >= 4 && cyc <= 6);
        #1;
        if (cyc <= 7) check("bp_in_ready", 66'(ir16), 66'(!(cyc >= 4 && cyc <= 6)));
        if (cyc == 4) frozen = {ovf16, cy16, 48'b0, sum16};
        if (cyc == 5 || cyc == 6)
          check("bp_frozen", {ov16, ovf16, cy16, 47'b0, sum16}, {1'b1, frozen[65:64], 47'b0, frozen[15:0]});
        if (ov16 && or16) begin
          if (bp_q.size() == 0) check("bp_extra_beat", 66'd1, 66'd0);
          else begin
            e = bp_q.pop_front();
            check("bp_result", {ovf16, cy16, 48'b0, sum16}, e);
            got++;
          end
        end
        if (iv16 && ir16) begin
          bp_q.push_back(model(16, {48'b0, a16}, {48'b0, b16}, cin16, sub16));
          sent++;
        end
      end
      check("bp_beat_count", 66'(got), 66'd6);
      @(negedge clk);
      iv16 = 1'b0;
      @(negedge clk);
      check("bp_no_dup", 66'(ov16), 66'd0);
    end

    // Reset with three beats in flight
    or16 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      iv16 = 1'b1; a16 = 16'h1000 + 16'(i); b16 = 16'h0101; cin16 = 1'b0; sub16 = 1'b0;
    end
    @(negedge clk);
    iv16 = 1'b0;
    #1;
    check("rst_pre_valid", 66'(ov16), 66'd1);
    #1 rst = 1'b1;
    #1;
    check("rst_flush", 66'({ov16, ovf16, cy16, sum16}), 66'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_quiet", 66'(ov16), 66'd0);
    end
    run_vec(tbl[1], "post_rst");

    // Random traffic on 32- and 64-bit instances
    fork
      begin : r32
        logic [65:0] q[$];
        logic [65:0] e;
        int sent, got, cyc;
        sent = 0; got = 0; cyc = 0;
        while (got < NR && cyc < LIM) begin
          @(negedge clk);
          cyc++;
          iv32  = (sent < NR) && ($urandom_range(0, 9) < 8);
          a32   = $urandom;
          b32   = $urandom;
          cin32 = 1'($urandom_range(0, 1));
          sub32 = 1'($urandom_range(0, 1));
          or32  = ($urandom_range(0, 3) != 0);
          #1;
          if (ov32 && or32) begin
            if (q.size() == 0) check("r32_extra_beat", 66'd1, 66'd0);
            else begin
              e = q.pop_front();
              check("r32_result", {ovf32, cy32, 32'b0, sum32}, e);
              got++;
            end
          end
          if (iv32 && ir32) begin
            q.push_back(model(32, {32'b0, a32}, {32'b0, b32}, cin32, sub32));
            sent++;
          end
        end
        if (got < NR) check("r32_timeout", 66'(got), 66'(NR));
      end
      begin : r64
        logic [65:0] q[$];
        logic [65:0] e;
        int sent, got, cyc;
        sent = 0; got = 0; cyc = 0;
        while (got < NR && cyc < LIM) begin
          @(negedge clk);
          cyc++;
          iv64  = (sent < NR) && ($urandom_range(0, 9) < 8);
          a64   = {$urandom, $urandom};
          b64   = {$urandom, $urandom};
          cin64 = 1'($urandom_range(0, 1));
          sub64 = 1'($urandom_range(0, 1));
          or64  = ($urandom_range(0, 3) != 0);
          #1;
          if (ov64 && or64) begin
            if (q.size() == 0) check("r64_extra_beat", 66'd1, 66'd0);
            else begin
              e = q.pop_front();
              check("r64_result", {ovf64, cy64, sum64}, e);
              got++;
            end
          end
          if (iv64 && ir64) begin
            q.push_back(model(64, a64, b64, cin64, sub64));
            sent++;
          end
        end
        if (got < NR) check("r64_timeout", 66'(got), 66'(NR));
      end
    join

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/brent_kung_adder_pipe.md
Name: brent_kung_adder_pipe

Overview:
Parametrised, pipelined Brent-Kung parallel-prefix adder/subtractor. It generalises the 16-bit combinational Brent-Kung adder to any power-of-two WIDTH. It adds a subtract mode, a signed-overflow flag, and a valid/ready handshake with backpressure. It sits in the datapath wherever a registered wide add/sub is needed at clock rate.

Parameters:
WIDTH, 16, operand/sum width in bits; power of two, 4..64.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand beat present
in_ready  output  1  block accepts beat this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in (add mode only)
sub  input  1  0 = A+B+cin, 1 = A-B (B inverted, carry-in forced 1, cin ignored)
out_valid  output  1  result beat present
out_ready  input  1  downstream accepts result
sum  output  WIDTH  result
carry  output  1  carry-out of MSB; in sub mode 1 = no borrow
ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Reset (async assert, sync release): all stage valid bits = 0, so out_valid = 0. sum, carry and ovf = 0. in_ready = 1 once reset is released.
- Pipeline is 3 register stages; latency is exactly 3 cycles from accept to out_valid when there is no stall.
  - S1: registers bit-level g = a & b', p = a ^ b', and the effective carry-in. Here b' = sub ? ~b : b, and the effective carry-in = sub ? 1 : cin.
  - S2: registers all prefix carries c[i] for i = 0..WIDTH from the Brent-Kung tree. The up-sweep has log2(WIDTH) levels and the down-sweep has log2(WIDTH)-1 levels. The effective carry-in is folded in as position -1. p is carried along with the carries.
  - S3: registers sum[i] = p[i] ^ c[i], carry = c[WIDTH], and ovf = c[WIDTH-1] ^ c[WIDTH].
- Handshake: advance = out_ready | ~out_valid, and in_ready = advance.
  - A beat is accepted when in_valid & in_ready.
  - When advance = 1, every stage shifts one place. A stage's valid loads the previous stage's valid; S1 valid loads in_valid.
  - When advance = 0, all stage registers and valid bits hold, and outputs stay stable.
- Bubbles are not collapsed: a stall freezes the whole pipeline, bubbles included.
- The result is transferred when out_valid & out_ready.
- Throughput is 1 beat per cycle with out_ready held high. Back-to-back beats are allowed, and per-beat sub/cin take effect independently.
- Data registers update only for valid beats. sum, carry and ovf hold their last value while out_valid = 0.
- Wrap-around: the sum is modulo 2^WIDTH. Overflow beyond WIDTH appears only on carry.
- Reset mid-operation: all in-flight beats are discarded. No partial result is emitted after reset.
- in_valid = 0 with in_ready = 1 inserts a bubble. out_ready may be high with out_valid low; no transfer occurs.
- The prefix tree is generated with generate loops over log2(WIDTH) levels. No hand-unrolled 16-bit netlist is used.

Test Plan:
1. WIDTH=16, add, a=0xCC2A, b=0xAA55, cin=0 -> after 3 cycles sum=0x767F, carry=1, ovf=1.
2. WIDTH=16, add, a=0x7FFF, b=0x05DF -> sum=0x85DE, carry=0, ovf=1. Also a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, carry=1, ovf=0.
3. WIDTH=16, sub, a=0x0F6A, b=0x005F, cin=1 (ignored) -> sum=0x0F0B, carry=1, ovf=0. Also a=0x0000, b=0x0001 -> sum=0xFFFF, carry=0, ovf=0.
4. Backpressure: stream 6 beats with out_ready low on cycles 4-6. Required: in_ready low on the same cycles, outputs frozen, no beat lost or duplicated, and results in order.
5. Assert rst with 3 beats in flight -> out_valid=0 immediately and stays 0 until new beats arrive. First output after release appears exactly 3 cycles after the first accepted beat.
6. WIDTH=32 and WIDTH=64, 10k random a/b/cin/sub with random out_ready -> every result matches the reference model {carry,sum} = a + (sub ? ~b : b) + (sub ? 1 : cin), and ovf is correct.
